// File: rtl/pixel_downscaler_pkg.sv
// Shared constants for the pixel downscaler: RGB565 field layout and the
// fixed-point luma coefficients used by the grayscale converter.
package pixel_downscaler_pkg;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  localparam logic [15:0] COEF_R = 16'd77;
  localparam logic [15:0] COEF_G = 16'd150;
  localparam logic [15:0] COEF_B = 16'd29;
  localparam int          GRAY_SHIFT = 8;

  // Replicate MSBs into the new LSBs so full-scale inputs map to 255.
  function automatic logic [7:0] expand5(input logic [4:0] v);
    return {v, v[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] v);
    return {v, v[5:4]};
  endfunction

endpackage

// File: rtl/pixel_downscaler_if.sv
// Pixel stream bundle: RGB565 input from capture, grayscale output toward
// the AXI write master.
interface pixel_downscaler_if #(
  parameter int RGB_PXL_W = 16,
  parameter int GS_PXL_W  = 8
);
  logic [RGB_PXL_W-1:0] dpc_pxl_i;
  logic                 dpc_sof_i;
  logic                 dpc_vld_i;
  logic                 dpc_rdy_o;
  logic [GS_PXL_W-1:0]  pdf_pxl_o;
  logic                 pdf_vld_o;
  logic                 pdf_rdy_i;

  modport slave (
    input  dpc_pxl_i, dpc_sof_i, dpc_vld_i, pdf_rdy_i,
    output dpc_rdy_o, pdf_pxl_o, pdf_vld_o
  );

  modport master (
    output dpc_pxl_i, dpc_sof_i, dpc_vld_i, pdf_rdy_i,
    input  dpc_rdy_o, pdf_pxl_o, pdf_vld_o
  );
endinterface

// File: rtl/pixel_gray_conv.sv
// Combinational RGB565 to 8-bit grayscale: weighted sum of expanded
// channels, truncated by the fixed-point shift.
module pixel_gray_conv
  import pixel_downscaler_pkg::*;
#(
  parameter int RGB_PXL_W = 16,
  parameter int GS_PXL_W  = 8
) (
  input  logic [RGB_PXL_W-1:0] rgb_i,
  output logic [GS_PXL_W-1:0]  gray_o
);

  logic [7:0]  r8;
  logic [7:0]  g8;
  logic [7:0]  b8;
  logic [15:0] wsum;

  // Worst case 256*255 = 65280, so the 16-bit sum never wraps.
  always_comb begin
    r8     = expand5(rgb_i[R_MSB:R_LSB]);
    g8     = expand6(rgb_i[G_MSB:G_LSB]);
    b8     = expand5(rgb_i[B_MSB:B_LSB]);
    wsum   = COEF_R * {8'd0, r8} + COEF_G * {8'd0, g8} + COEF_B * {8'd0, b8};
    gray_o = GS_PXL_W'(wsum >> GRAY_SHIFT);
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head holds the last popped
// word while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] lastOut_q;
  logic             empty;
  logic             full;
  logic             wrOk;
  logic             rdOk;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign wrOk  = wr_en_i & ~full;
  assign rdOk  = rd_en_i & ~empty;

  always_ff @(posedge clk) begin
    if (wrOk) mem_q[wrPtr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      lastOut_q <= '0;
    end else begin
      if (wrOk) wrPtr_q <= wrPtr_q + 1'b1;
      if (rdOk) begin
        rdPtr_q   <= rdPtr_q + 1'b1;
        lastOut_q <= mem_q[rdPtr_q];
      end
      case ({wrOk, rdOk})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data_o = empty ? lastOut_q : mem_q[rdPtr_q];
  assign empty_o   = empty;
  assign count_o   = count_q;

endmodule

// File: rtl/pixel_downscaler.sv
// RGB565 raster stream to 2x2-averaged grayscale: convert, pair horizontally,
// combine with the stored even row, and queue results in an output FIFO.
module pixel_downscaler
  import pixel_downscaler_pkg::*;
#(
  parameter int IN_W       = 640,
  parameter int IN_H       = 480,
  parameter int RGB_PXL_W  = 16,
  parameter int GS_PXL_W   = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  pixel_downscaler_if.slave  bus
);

  localparam int COL_W = $clog2(IN_W);
  localparam int ROW_W = $clog2(IN_H);
  localparam int IDX_W = $clog2(IN_W/2);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                inHs;
  logic [GS_PXL_W-1:0] grayIn;
  logic [COL_W-1:0]    curCol;
  logic [ROW_W-1:0]    curRow;
  logic [COL_W-1:0]    colCnt_q, colCnt_d;
  logic [ROW_W-1:0]    rowCnt_q, rowCnt_d;

  logic                s1Vld_q;
  logic [GS_PXL_W-1:0] s1Gray_q;
  logic                s1OddCol_q;
  logic                s1OddRow_q;
  logic [IDX_W-1:0]    s1Idx_q;
  logic [GS_PXL_W-1:0] hold_q;

  logic [GS_PXL_W:0]   pair;
  logic [GS_PXL_W+1:0] sum;
  logic [GS_PXL_W:0]   lineBuf_q [IN_W/2];
  logic                s2Wr_q;
  logic [GS_PXL_W-1:0] s2Pxl_q;

  logic [CNT_W-1:0]    fifoCnt;
  logic                fifoEmpty;
  logic [GS_PXL_W-1:0] fifoHead;

  assign inHs = bus.dpc_vld_i & bus.dpc_rdy_o;

  pixel_gray_conv #(.RGB_PXL_W(RGB_PXL_W), .GS_PXL_W(GS_PXL_W)) u_gray (
    .rgb_i  (bus.dpc_pxl_i),
    .gray_o (grayIn)
  );

  // SOF overrides the counters, which is what discards any partial block.
  always_comb begin
    curCol   = bus.dpc_sof_i ? '0 : colCnt_q;
    curRow   = bus.dpc_sof_i ? '0 : rowCnt_q;
    colCnt_d = colCnt_q;
    rowCnt_d = rowCnt_q;
    if (inHs) begin
      if (curCol == COL_W'(IN_W-1)) begin
        colCnt_d = '0;
        rowCnt_d = (curRow == ROW_W'(IN_H-1)) ? '0 : curRow + 1'b1;
      end else begin
        colCnt_d = curCol + 1'b1;
        rowCnt_d = curRow;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colCnt_q   <= '0;
      rowCnt_q   <= '0;
      s1Vld_q    <= 1'b0;
      s1Gray_q   <= '0;
      s1OddCol_q <= 1'b0;
      s1OddRow_q <= 1'b0;
      s1Idx_q    <= '0;
    end else begin
      colCnt_q <= colCnt_d;
      rowCnt_q <= rowCnt_d;
      s1Vld_q  <= inHs;
      if (inHs) begin
        s1Gray_q   <= grayIn;
        s1OddCol_q <= curCol[0];
        s1OddRow_q <= curRow[0];
        s1Idx_q    <= IDX_W'(curCol >> 1);
      end
    end
  end

  always_comb begin
    pair = {1'b0, hold_q} + {1'b0, s1Gray_q};
    sum  = {1'b0, pair} + {1'b0, lineBuf_q[s1Idx_q]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      s2Wr_q  <= 1'b0;
      s2Pxl_q <= '0;
    end else begin
      s2Wr_q <= s1Vld_q & s1OddCol_q & s1OddRow_q;
      if (s1Vld_q & ~s1OddCol_q) hold_q <= s1Gray_q;
      if (s1Vld_q & s1OddCol_q & s1OddRow_q) s2Pxl_q <= GS_PXL_W'(sum >> 2);
    end
  end

  always_ff @(posedge clk) begin
    if (s1Vld_q & s1OddCol_q & ~s1OddRow_q) lineBuf_q[s1Idx_q] <= pair;
  end

  sync_fifo #(.WIDTH(GS_PXL_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (s2Wr_q),
    .wr_data_i (s2Pxl_q),
    .rd_en_i   (bus.pdf_rdy_i),
    .rd_data_o (fifoHead),
    .empty_o   (fifoEmpty),
    .count_o   (fifoCnt)
  );

  // Two slots stay free for results already inside the pipeline.
  assign bus.dpc_rdy_o = (fifoCnt < CNT_W'(FIFO_DEPTH-2));
  assign bus.pdf_vld_o = ~fifoEmpty;
  assign bus.pdf_pxl_o = fifoHead;

endmodule

// File: tb/tb_pixel_downscaler.sv
// Directed bench for pixel_downscaler on a 4x2 frame with a scoreboard of
// expected grayscale outputs popped as the FIFO delivers them.
module tb_pixel_downscaler;

  localparam int IN_W       = 4;
  localparam int IN_H       = 2;
  localparam int FIFO_DEPTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pixel_downscaler_if #(.RGB_PXL_W(16), .GS_PXL_W(8)) bus ();

  pixel_downscaler #(
    .IN_W(IN_W), .IN_H(IN_H), .RGB_PXL_W(16), .GS_PXL_W(8), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] sb[$];
  bit         useModel    = 1'b1;
  int         mCol        = 0;
  int         mRow        = 0;
  int         mHold       = 0;
  int         mLine [IN_W/2];
  int         acceptedCnt;
  bit         ok;
  logic [15:0] rp;
  logic [15:0] fr [8];
  logic [7:0]  monExp;

  function automatic int refGray(input logic [15:0] p);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    r8 = (r5 << 3) | (r5 >> 2);
    g8 = (g6 << 2) | (g6 >> 4);
    b8 = (b5 << 3) | (b5 >> 2);
    return (77*r8 + 150*g8 + 29*b8) >> 8;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour of one accepted pixel: position, pairing, averaging.
  task automatic modelAccept(input logic [15:0] pxl, input bit sof);
    int g, pairV;
    if (sof) begin
      mCol = 0;
      mRow = 0;
    end
    g = refGray(pxl);
    if (mCol % 2 == 0) begin
      mHold = g;
    end else begin
      pairV = mHold + g;
      if (mRow % 2 == 0) mLine[mCol/2] = pairV;
      else if (useModel) sb.push_back(8'((pairV + mLine[mCol/2]) >> 2));
    end
    mCol++;
    if (mCol == IN_W) begin
      mCol = 0;
      mRow++;
      if (mRow == IN_H) mRow = 0;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] pxl, input bit sof, input int maxWait, output bit accepted);
    bus.dpc_pxl_i = pxl;
    bus.dpc_sof_i = sof;
    bus.dpc_vld_i = 1'b1;
    accepted = 1'b0;
    for (int w = 0; w < maxWait && !accepted; w++) begin
      @(negedge clk);
      if (bus.dpc_rdy_o) accepted = 1'b1;
    end
    if (accepted) begin
      @(posedge clk);
      #1;
      modelAccept(pxl, sof);
    end
    bus.dpc_vld_i = 1'b0;
    bus.dpc_sof_i = 1'b0;
  endtask

  task automatic sendPixel(input logic [15:0] pxl, input bit sof);
    bit acc;
    applyStimulus(pxl, sof, 200, acc);
    checkOutput("handshake", 32'(acc), 32'd1);
  endtask

  task automatic sendFrame(input logic [15:0] px [8], input logic [7:0] e0, input logic [7:0] e1);
    sb.push_back(e0);
    sb.push_back(e1);
    useModel = 1'b0;
    for (int i = 0; i < 8; i++) sendPixel(px[i], i == 0);
    useModel = 1'b1;
  endtask

  task automatic waitDrain(input string tag);
    for (int c = 0; c < 500 && sb.size() != 0; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    checkOutput({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  // Every delivered output is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.pdf_vld_o && bus.pdf_rdy_i) begin
      if (sb.size() == 0) begin
        vectors++;
        assert (sb.size() != 0) else begin
          miscompares++;
          $error("[TB] FAIL unexpected_output observed=0x%0h expected=none", bus.pdf_pxl_o);
        end
      end else begin
        monExp = sb.pop_front();
        checkOutput("pixel_out", 32'(bus.pdf_pxl_o), 32'(monExp));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.dpc_pxl_i = '0;
    bus.dpc_sof_i = 1'b0;
    bus.dpc_vld_i = 1'b0;
    bus.pdf_rdy_i = 1'b1;
    #1;
    checkOutput("reset_rdy", 32'(bus.dpc_rdy_o), 32'd1);
    checkOutput("reset_vld", 32'(bus.pdf_vld_o), 32'd0);
    checkOutput("reset_pxl", 32'(bus.pdf_pxl_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] white frame with latency check");
    sb.push_back(8'hFF);
    sb.push_back(8'hFF);
    useModel = 1'b0;
    for (int i = 0; i < 6; i++) sendPixel(16'hFFFF, i == 0);
    @(negedge clk);
    checkOutput("lat_edge0", 32'(bus.pdf_vld_o), 32'd0);
    @(negedge clk);
    checkOutput("lat_edge1", 32'(bus.pdf_vld_o), 32'd0);
    @(negedge clk);
    checkOutput("lat_edge2", 32'(bus.pdf_vld_o), 32'd1);
    sendPixel(16'hFFFF, 1'b0);
    sendPixel(16'hFFFF, 1'b0);
    useModel = 1'b1;
    waitDrain("white");
    checkOutput("empty_vld", 32'(bus.pdf_vld_o), 32'd0);
    checkOutput("empty_hold", 32'(bus.pdf_pxl_o), 32'hFF);

    $display("[TB] pure colour frames");
    foreach (fr[i]) fr[i] = 16'hF800;
    sendFrame(fr, 8'h4C, 8'h4C);
    waitDrain("red");
    foreach (fr[i]) fr[i] = 16'h07E0;
    sendFrame(fr, 8'h95, 8'h95);
    waitDrain("green");
    foreach (fr[i]) fr[i] = 16'h001F;
    sendFrame(fr, 8'h1C, 8'h1C);
    waitDrain("blue");

    $display("[TB] averaging frame");
    fr = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    sendFrame(fr, 8'h7F, 8'h7F);
    waitDrain("avg");

    $display("[TB] sof resync at col 3 row 1");
    for (int i = 0; i < 7; i++) begin
      rp = 16'($urandom);
      sendPixel(rp, i == 0);
    end
    for (int i = 0; i < 8; i++) begin
      rp = 16'($urandom);
      sendPixel(rp, i == 0);
    end
    waitDrain("sof");

    $display("[TB] backpressure");
    bus.pdf_rdy_i = 1'b0;
    acceptedCnt = 0;
    for (int i = 0; i < 200; i++) begin
      rp = 16'($urandom);
      applyStimulus(rp, (i % 8) == 0, 3, ok);
      if (!ok) break;
      acceptedCnt++;
    end
    checkOutput("bp_accepted", 32'(acceptedCnt), 32'd122);
    repeat (4) @(negedge clk);
    checkOutput("bp_rdy_low", 32'(bus.dpc_rdy_o), 32'd0);
    checkOutput("bp_vld_full", 32'(bus.pdf_vld_o), 32'd1);
    bus.pdf_rdy_i = 1'b1;
    for (int i = acceptedCnt; i < 128; i++) begin
      rp = 16'($urandom);
      sendPixel(rp, (i % 8) == 0);
    end
    waitDrain("bp");

    $display("[TB] reset mid-frame");
    bus.pdf_rdy_i = 1'b0;
    for (int i = 0; i < 13; i++) begin
      rp = 16'($urandom);
      sendPixel(rp, i == 0);
    end
    checkOutput("pre_rst_vld", 32'(bus.pdf_vld_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_vld", 32'(bus.pdf_vld_o), 32'd0);
    checkOutput("rst_rdy", 32'(bus.dpc_rdy_o), 32'd1);
    sb.delete();
    mCol = 0;
    mRow = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.pdf_rdy_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rp = 16'($urandom);
      sendPixel(rp, 1'b0);
    end
    waitDrain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
